// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - 16x oversampled 8N1 UART receive front end with valid/ack byte holding
module uart_rx_frontend #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          rxd_meta;
    logic          rxs;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    samp_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic tick;
    logic mid_start;
    logic bit_end;
    logic cnt_clr;
    logic shift_en;
    logic load_byte;
    logic set_ovr;
    logic set_ferr;

    assign tick      = ((state == S_START) || (state == S_DATA) || (state == S_STOP))
                       && (tick_cnt == TICK_LAST);
    assign mid_start = tick && (samp_cnt == 4'd7);
    assign bit_end   = tick && (samp_cnt == 4'd15);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        load_byte  = 1'b0;
        set_ovr    = 1'b0;
        set_ferr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    state_next = S_START;
                    cnt_clr    = 1'b1;
                end
            end
            S_START: begin
                if (mid_start) begin
                    if (rxs) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_DATA;
                        cnt_clr    = 1'b1;
                    end
                end
            end
            S_DATA: begin
                // Counting 16 ticks from the start-bit midpoint lands each sample mid-bit.
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (rxs) begin
                        if (!rx_valid || rx_ack) begin
                            load_byte = 1'b1;
                        end else begin
                            set_ovr = 1'b1;
                        end
                        state_next = S_IDLE;
                    end else begin
                        set_ferr   = 1'b1;
                        state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A line held low must go high before another start bit can be seen.
                if (rxs) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            rxd_meta  <= 1'b1;
            rxs       <= 1'b1;
            tick_cnt  <= '0;
            samp_cnt  <= 4'd0;
            bit_idx   <= 3'd0;
            shift     <= 8'd0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rxd_meta <= rxd;
            rxs      <= rxd_meta;
            rx_busy  <= (state_next != S_IDLE);

            if ((state == S_IDLE) || (state == S_BREAK) || cnt_clr) begin
                tick_cnt <= '0;
            end else if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end

            if ((state == S_IDLE) || cnt_clr) begin
                samp_cnt <= 4'd0;
            end else if (tick) begin
                samp_cnt <= samp_cnt + 4'd1;
            end

            if (state != S_DATA) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (shift_en) begin
                shift[bit_idx] <= rxs;
            end

            if (load_byte) begin
                rx_data <= shift;
            end

            // A completing byte takes priority over the clear from an ack.
            if (load_byte) begin
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            if (set_ferr) begin
                frame_err <= 1'b1;
            end else if (rx_ack) begin
                frame_err <= 1'b0;
            end

            if (set_ovr) begin
                overrun <= 1'b1;
            end else if (rx_ack) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb/tb_uart_rx_frontend.sv - directed self-checking bench for uart_rx_frontend at 16 cycles per bit
module tb_uart_rx_frontend;

    logic       sysclk;
    logic       reset;
    logic       rxd;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int n_checks;
    int n_fail;
    int lat;

    uart_rx_frontend #(
        .CLK_FREQ   (1600),
        .BAUD       (100),
        .OVERSAMPLE (16)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rxd = 1'b0;
        repeat (16) step();
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (16) step();
        end
        rxd = stop;
        repeat (16) step();
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        step();
        rx_ack = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        rxd      = 1'b1;
        rx_ack   = 1'b0;
        repeat (4) step();
        reset = 1'b0;
        step();

        check_eq("rst_data", {24'd0, rx_data}, 32'h00);
        check_eq("rst_valid", {31'd0, rx_valid}, 0);
        check_eq("rst_busy", {31'd0, rx_busy}, 0);
        check_eq("rst_ferr", {31'd0, frame_err}, 0);
        check_eq("rst_ovr", {31'd0, overrun}, 0);

        // Nominal byte with latency measurement from the falling edge of rxd
        fork
            send_frame(8'hA5, 1'b1);
            begin
                lat = 0;
                while (!rx_valid && lat < 400) begin
                    step();
                    lat++;
                end
            end
        join
        check_eq("nom_latency_window", {31'd0, (lat >= 151 && lat <= 157)}, 1);
        check_eq("nom_data", {24'd0, rx_data}, 32'hA5);
        check_eq("nom_valid", {31'd0, rx_valid}, 1);
        check_eq("nom_ferr", {31'd0, frame_err}, 0);
        check_eq("nom_ovr", {31'd0, overrun}, 0);
        check_eq("nom_busy", {31'd0, rx_busy}, 0);
        pulse_ack();
        check_eq("nom_ack_valid", {31'd0, rx_valid}, 0);

        // Glitch rejection
        rxd = 1'b0;
        repeat (4) step();
        check_eq("glitch_busy_hi", {31'd0, rx_busy}, 1);
        rxd = 1'b1;
        repeat (12) step();
        check_eq("glitch_busy_lo", {31'd0, rx_busy}, 0);
        check_eq("glitch_valid", {31'd0, rx_valid}, 0);
        check_eq("glitch_ferr", {31'd0, frame_err}, 0);
        send_frame(8'h3C, 1'b1);
        check_eq("after_glitch_valid", {31'd0, rx_valid}, 1);
        check_eq("after_glitch_data", {24'd0, rx_data}, 32'h3C);
        pulse_ack();

        // Framing error followed by a held-low line
        send_frame(8'h55, 1'b0);
        repeat (40) step();
        check_eq("ferr_flag", {31'd0, frame_err}, 1);
        check_eq("ferr_valid", {31'd0, rx_valid}, 0);
        check_eq("ferr_busy_held", {31'd0, rx_busy}, 1);
        check_eq("ferr_data_kept", {24'd0, rx_data}, 32'h3C);
        rxd = 1'b1;
        repeat (5) step();
        check_eq("ferr_busy_released", {31'd0, rx_busy}, 0);
        send_frame(8'h0F, 1'b1);
        check_eq("ferr_next_data", {24'd0, rx_data}, 32'h0F);
        check_eq("ferr_next_valid", {31'd0, rx_valid}, 1);
        check_eq("ferr_sticky", {31'd0, frame_err}, 1);
        pulse_ack();
        check_eq("ferr_ack_clear", {31'd0, frame_err}, 0);

        // Overrun
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check_eq("ovr_data_old", {24'd0, rx_data}, 32'h11);
        check_eq("ovr_flag", {31'd0, overrun}, 1);
        check_eq("ovr_valid", {31'd0, rx_valid}, 1);
        pulse_ack();
        check_eq("ovr_ack_flag", {31'd0, overrun}, 0);
        check_eq("ovr_ack_valid", {31'd0, rx_valid}, 0);

        // Ack coinciding with the stop-bit sample of the second byte
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (154) step();
                rx_ack = 1'b1;
                step();
                rx_ack = 1'b0;
            end
        join
        check_eq("simul_data", {24'd0, rx_data}, 32'h22);
        check_eq("simul_valid", {31'd0, rx_valid}, 1);
        check_eq("simul_ovr", {31'd0, overrun}, 0);
        pulse_ack();

        // Reset during data bit 3 of 0xFF; the rest of the line stays high
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (16 + 16 * 3 + 8) step();
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
        join
        repeat (20) step();
        check_eq("rstmid_valid", {31'd0, rx_valid}, 0);
        check_eq("rstmid_busy", {31'd0, rx_busy}, 0);
        check_eq("rstmid_data", {24'd0, rx_data}, 32'h00);
        check_eq("rstmid_ferr", {31'd0, frame_err}, 0);
        check_eq("rstmid_ovr", {31'd0, overrun}, 0);
        send_frame(8'h81, 1'b1);
        check_eq("rstmid_next_data", {24'd0, rx_data}, 32'h81);
        check_eq("rstmid_next_valid", {31'd0, rx_valid}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
